// File: rtl/effect_chain_sequencer.sv
// Walks one latched sample through the enabled effect slots in index order,
// skipping hung slots after TIMEOUT wait cycles, and emits the final sample.
module effect_chain_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int N_EFFECTS  = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sample_valid,
  input  logic [DATA_WIDTH-1:0]           sample_in,
  input  logic [N_EFFECTS-1:0]            effect_enable,
  input  logic [N_EFFECTS*DATA_WIDTH-1:0] effect_out,
  input  logic [N_EFFECTS-1:0]            effect_done,
  input  logic                            clear_status,
  output logic [DATA_WIDTH-1:0]           effect_data,
  output logic [N_EFFECTS-1:0]            my_turn,
  output logic [N_EFFECTS-1:0]            cs,
  output logic [DATA_WIDTH-1:0]           sample_out,
  output logic                            sample_out_valid,
  output logic                            busy,
  output logic                            overrun,
  output logic                            timeout_err
);

  localparam int                IDX_W    = $clog2(N_EFFECTS + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_EFFECTS);
  localparam logic [7:0]        TCNT_MAX = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_WAIT,
    S_OUTPUT
  } state_t;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0]  cur_q, cur_d;
  logic [N_EFFECTS-1:0]          en_lat_q, en_lat_d;
  logic [7:0]                    tcnt_q, tcnt_d;
  logic signed [DATA_WIDTH-1:0]  sample_out_q, sample_out_d;
  logic                          overrun_q, overrun_d;
  logic                          timeout_err_q, timeout_err_d;
  logic                          timeout_set;

  logic                          en_sel;
  logic                          done_sel;
  logic signed [DATA_WIDTH-1:0]  res_sel;

  // Per-slot views of the current index; idx==N_EFFECTS matches no slot.
  always_comb begin
    en_sel   = 1'b0;
    done_sel = 1'b0;
    res_sel  = '0;
    my_turn  = '0;
    for (int i = 0; i < N_EFFECTS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        en_sel     = en_lat_q[i];
        done_sel   = effect_done[i];
        res_sel    = effect_out[i*DATA_WIDTH +: DATA_WIDTH];
        my_turn[i] = (state_q == S_ISSUE);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cur_d        = cur_q;
    en_lat_d     = en_lat_q;
    tcnt_d       = tcnt_q;
    sample_out_d = sample_out_q;
    timeout_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sample_valid) begin
          cur_d    = sample_in;
          en_lat_d = effect_enable;
          idx_d    = '0;
          state_d  = S_SELECT;
        end
      end
      S_SELECT: begin
        if (idx_q == IDX_LAST) begin
          sample_out_d = cur_q;
          state_d      = S_OUTPUT;
        end else if (en_sel) begin
          tcnt_d  = '0;
          state_d = S_ISSUE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (done_sel) begin
          cur_d   = res_sel;
          idx_d   = idx_q + 1'b1;
          state_d = S_SELECT;
        end else if (tcnt_q == TCNT_MAX) begin
          // Hung slot: skip it and keep the previous stage's sample.
          timeout_set = 1'b1;
          idx_d       = idx_q + 1'b1;
          state_d     = S_SELECT;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      S_OUTPUT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Set has priority over clear on the sticky flags.
  assign overrun_d     = (sample_valid && (state_q != S_IDLE)) || (overrun_q && !clear_status);
  assign timeout_err_d = timeout_set || (timeout_err_q && !clear_status);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      cur_q         <= '0;
      en_lat_q      <= '0;
      tcnt_q        <= '0;
      sample_out_q  <= '0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cur_q         <= cur_d;
      en_lat_q      <= en_lat_d;
      tcnt_q        <= tcnt_d;
      sample_out_q  <= sample_out_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign effect_data      = cur_q;
  assign cs               = en_lat_q;
  assign sample_out       = sample_out_q;
  assign sample_out_valid = (state_q == S_OUTPUT);
  assign busy             = (state_q != S_IDLE);
  assign overrun          = overrun_q;
  assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_effect_chain_sequencer.sv
// Scoreboard bench: two mock effects (2x and x+1) around a 2-slot sequencer.
module tb_effect_chain_sequencer;

  localparam int DW = 16;
  localparam int NE = 2;
  localparam int TO = 16;

  logic          clk;
  logic          rst;
  logic          sample_valid;
  logic [DW-1:0] sample_in;
  logic [NE-1:0] effect_enable;
  logic [NE*DW-1:0] out_m = '0;
  logic [NE-1:0] done_m = '0;
  logic          clear_status;
  logic [DW-1:0] effect_data;
  logic [NE-1:0] my_turn;
  logic [NE-1:0] cs;
  logic [DW-1:0] sample_out;
  logic          sample_out_valid;
  logic          busy;
  logic          overrun;
  logic          timeout_err;

  logic [NE-1:0] hang_mask;
  logic [NE-1:0] force_done;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;
  int n_out = 0;
  int mt_count = 0;
  logic prev_mt = 1'b0;
  int t0;
  int mt0;
  int n0;

  effect_chain_sequencer #(.DATA_WIDTH(DW), .N_EFFECTS(NE), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .effect_enable(effect_enable), .effect_out(out_m), .effect_done(done_m),
    .clear_status(clear_status), .effect_data(effect_data), .my_turn(my_turn),
    .cs(cs), .sample_out(sample_out), .sample_out_valid(sample_out_valid),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mock effects answer one cycle after their start pulse unless hung.
  always @(posedge clk) begin
    done_m[0] <= (my_turn[0] && !hang_mask[0]) || force_done[0];
    done_m[1] <= (my_turn[1] && !hang_mask[1]) || force_done[1];
    out_m[0*DW +: DW] <= effect_data << 1;
    out_m[1*DW +: DW] <= effect_data + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [DW-1:0] x, input logic [NE-1:0] en,
                                           input logic [NE-1:0] hang);
    logic [DW-1:0] v;
    v = x;
    if (en[0] && !hang[0]) v = v << 1;
    if (en[1] && !hang[1]) v = v + 16'd1;
    return v;
  endfunction

  function automatic int latency(input logic [NE-1:0] en, input logic [NE-1:0] hang);
    int l;
    l = 2;
    for (int i = 0; i < NE; i++) begin
      if (!en[i])       l += 1;
      else if (hang[i]) l += 2 + TO;
      else              l += 3;
    end
    return l;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (sample_out_valid) begin
        n_out++;
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(sample_out), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sample_out", 32'(sample_out), 32'(e.data));
          chk("out_latency", 32'(cyc), 32'(e.cyc));
        end
      end
      if (my_turn != '0) begin
        mt_count++;
        chk("my_turn_onehot", 32'($onehot(my_turn)), 32'd1);
        chk("my_turn_gap", 32'(prev_mt), 32'd0);
      end
      prev_mt = (my_turn != '0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic send(input logic [DW-1:0] x, input logic [NE-1:0] en, input bit push, output int t);
    exp_t e;
    t             = cyc;
    sample_valid  = 1'b1;
    sample_in     = x;
    effect_enable = en;
    if (push) begin
      e.data = model(x, en, hang_mask);
      e.cyc  = t + latency(en, hang_mask);
      sb.push_back(e);
    end
    step();
    sample_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while (sb.size() != 0 && b > 0) begin
      step();
      b--;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; sample_valid = 1'b0; sample_in = '0; effect_enable = '0;
    clear_status = 1'b0; hang_mask = '0; force_done = '0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_my_turn", 32'(my_turn), 32'd0);
    chk("rst_cs", 32'(cs), 32'd0);
    chk("rst_effect_data", 32'(effect_data), 32'd0);
    chk("rst_sample_out", 32'(sample_out), 32'd0);
    chk("rst_valid", 32'(sample_out_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b1;
    step();

    // Two-stage chain: 0x0100 -> 0x0201
    send(16'h0100, 2'b11, 1, t0);
    wait_to(t0 + 2);
    chk("mt_stage0", 32'(my_turn), 32'd1);
    wait_to(t0 + 5);
    chk("mt_stage1", 32'(my_turn), 32'd2);
    drain(100);

    // All disabled: passthrough, no start pulses
    mt0 = mt_count;
    send(16'h1234, 2'b00, 1, t0);
    drain(100);
    chk("no_my_turn", 32'(mt_count), 32'(mt0));

    // Timeout on slot 1
    hang_mask = 2'b10;
    send(16'h0100, 2'b11, 1, t0);
    drain(100);
    hang_mask = 2'b00;
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    repeat (3) step();
    chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
    pulse_clear();
    chk("timeout_err_clr", 32'(timeout_err), 32'd0);

    // Overrun during WAIT, with simultaneous clear (set wins)
    send(16'h0005, 2'b11, 1, t0);
    wait_to(t0 + 3);
    sample_valid = 1'b1; sample_in = 16'h7FFF; clear_status = 1'b1;
    step();
    sample_valid = 1'b0; clear_status = 1'b0;
    chk("overrun_set_wins", 32'(overrun), 32'd1);
    wait_to(t0 + 5);
    pulse_clear();
    chk("overrun_clr", 32'(overrun), 32'd0);
    drain(100);
    send(16'h0010, 2'b00, 1, t0);
    chk("no_new_overrun", 32'(overrun), 32'd0);
    drain(100);

    // Sample arriving in the OUTPUT cycle is an overrun
    send(16'h0020, 2'b00, 1, t0);
    wait_to(t0 + 4);
    sample_valid = 1'b1; sample_in = 16'h1111;
    step();
    sample_valid = 1'b0;
    chk("overrun_in_output", 32'(overrun), 32'd1);
    drain(100);
    repeat (6) step();
    pulse_clear();

    // Mask changes mid-run do not affect the current sample
    send(16'h0003, 2'b11, 1, t0);
    effect_enable = 2'b00;
    wait_to(t0 + 3);
    chk("cs_latched", 32'(cs), 32'd3);
    drain(100);
    send(16'h0003, 2'b00, 1, t0);
    drain(100);

    // Reset in the middle of WAIT; a late done must be ignored
    hang_mask = 2'b01;
    send(16'h0042, 2'b11, 0, t0);
    wait_to(t0 + 3);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_my_turn", 32'(my_turn), 32'd0);
    chk("mid_rst_cs", 32'(cs), 32'd0);
    chk("mid_rst_effect_data", 32'(effect_data), 32'd0);
    chk("mid_rst_sample_out", 32'(sample_out), 32'd0);
    chk("mid_rst_valid", 32'(sample_out_valid), 32'd0);
    n0 = n_out;
    force_done = 2'b01;
    step();
    force_done = 2'b00;
    repeat (20) step();
    chk("no_out_after_reset", 32'(n_out), 32'(n0));
    chk("idle_after_reset", 32'(busy), 32'd0);
    hang_mask = 2'b00;

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
